// File: rtl/dbus_sram_ctrl.sv
// dbus_sram_ctrl
// Sequential bridge from the core data-bus request/response port to a
// synchronous single-port data SRAM with one-cycle read latency.
// Each accepted request is held in a one-entry buffer. Its virtual address
// is translated by folding kseg0/kseg1 to physical. Alignment is checked,
// one SRAM access is issued per legal request, and a data_ok response is
// returned.
//
// State table:
//   IDLE  | no request in flight, ready to accept
//   ISSUE | SRAM access driven from the buffer, not accepting
//   WAIT  | SRAM read data on sram_rdata, data_ok response, accepting
//   ERR   | illegal request answered with data_ok+err, accepting
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   req_valid/addr/size/strobe/wdata     core request
//   resp_addr_ok                         request accepted when req_valid high
//   resp_data_ok/rdata/err               one-cycle response per request
//   sram_en/wen/addr/wdata               SRAM access (physical address)
//   sram_rdata                           SRAM read data, cycle after sram_en
`timescale 1ns/1ps
module dbus_sram_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_wdata,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t      state, state_nxt;
  logic        run;
  logic [31:0] buf_addr;
  logic [31:0] buf_wdata;
  logic [3:0]  buf_strobe;
  logic        legal;
  logic        accept;

  always_comb begin
    legal = 1'b0;
    case (req_size)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~req_addr[0];
      3'd2:    legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // run holds addr_ok low until the first edge after reset release, so no
  // output is combinationally derived from resetn.
  assign resp_addr_ok = run && (state != ISSUE);
  assign accept       = req_valid && resp_addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      run        <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      buf_strobe <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (accept) begin
        buf_addr   <= req_addr;
        buf_wdata  <= req_wdata;
        buf_strobe <= req_strobe;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    resp_data_ok = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    sram_en      = 1'b0;
    sram_wen     = 4'b0000;
    case (state)
      ISSUE: begin
        sram_en   = 1'b1;
        sram_wen  = buf_strobe;
        state_nxt = WAIT;
      end
      WAIT: begin
        resp_data_ok = 1'b1;
        resp_rdata   = sram_rdata;
      end
      ERR: begin
        resp_data_ok = 1'b1;
        resp_err     = 1'b1;
      end
      default: ;
    endcase
    // IDLE, WAIT and ERR all share the same accept decision; the response
    // of the current cycle comes from state, not from the new request.
    if (state != ISSUE) begin
      if (accept) state_nxt = legal ? ISSUE : ERR;
      else        state_nxt = IDLE;
    end
  end

  // kseg0 (100) and kseg1 (101) fold to physical; kuseg/kseg2/kseg3 pass.
  assign sram_addr  = (buf_addr[31:30] == 2'b10) ? {3'b000, buf_addr[28:0]} : buf_addr;
  assign sram_wdata = buf_wdata;

endmodule

// File: tb/tb_dbus_sram_ctrl.sv
`timescale 1ns/1ps
module tb_dbus_sram_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  dbus_sram_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_strobe(req_strobe), .req_wdata(req_wdata),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [2:0] s,
                         input logic [3:0] st, input logic [31:0] wd);
    req_valid = v; req_addr = a; req_size = s; req_strobe = st; req_wdata = wd;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    sram_rdata = 32'h0;
    step(); step();
    chk_cnt++; if (resp_addr_ok !== 1'b0) $display("FAIL rst_addr_ok: got %b want 0", resp_addr_ok); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b0 || sram_wen !== 4'h0) $display("FAIL rst_sram: got en=%b wen=%h want 0/0", sram_en, sram_wen); else pass_cnt++;
    chk_cnt++; if (resp_data_ok !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) $display("FAIL rst_resp: got ok=%b err=%b rdata=%h want 0", resp_data_ok, resp_err, resp_rdata); else pass_cnt++;
    chk_cnt++; if (sram_addr !== 32'h0 || sram_wdata !== 32'h0) $display("FAIL rst_buf: got addr=%h wdata=%h want 0", sram_addr, sram_wdata); else pass_cnt++;
    resetn = 1'b1;
    step();
    chk_cnt++; if (resp_addr_ok !== 1'b1) $display("FAIL rel_addr_ok: got %b want 1", resp_addr_ok); else pass_cnt++;
  endtask

  task automatic test_read_word();
    set_req(1'b1, 32'h8000_1000, 3'd2, 4'h0, 32'h0);
    step();
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    sram_rdata = 32'hDEAD_BEEF;
    chk_cnt++; if (sram_en !== 1'b1 || sram_wen !== 4'h0) $display("FAIL rd_en: got en=%b wen=%h want 1/0", sram_en, sram_wen); else pass_cnt++;
    chk_cnt++; if (sram_addr !== 32'h0000_1000) $display("FAIL rd_addr: got %h want 00001000", sram_addr); else pass_cnt++;
    chk_cnt++; if (resp_addr_ok !== 1'b0 || resp_data_ok !== 1'b0) $display("FAIL rd_issue_hs: got aok=%b dok=%b want 0/0", resp_addr_ok, resp_data_ok); else pass_cnt++;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b1 || resp_err !== 1'b0) $display("FAIL rd_resp: got ok=%b err=%b want 1/0", resp_data_ok, resp_err); else pass_cnt++;
    chk_cnt++; if (resp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", resp_rdata); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b0) $display("FAIL rd_wait_en: got %b want 0", sram_en); else pass_cnt++;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b0) $display("FAIL rd_idle_ok: got %b want 0", resp_data_ok); else pass_cnt++;
  endtask

  task automatic test_byte_write();
    set_req(1'b1, 32'hBFC0_0003, 3'd0, 4'b1000, 32'h5A00_0000);
    step();
    set_req(1'b0, 32'h1234_5678, 3'd2, 4'hF, 32'hFFFF_FFFF);
    chk_cnt++; if (sram_addr !== 32'h1FC0_0003) $display("FAIL wr_addr: got %h want 1fc00003", sram_addr); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b1 || sram_wen !== 4'b1000) $display("FAIL wr_wen: got en=%b wen=%b want 1/1000", sram_en, sram_wen); else pass_cnt++;
    chk_cnt++; if (sram_wdata !== 32'h5A00_0000) $display("FAIL wr_wdata: got %h want 5a000000", sram_wdata); else pass_cnt++;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b1 || resp_err !== 1'b0) $display("FAIL wr_resp: got ok=%b err=%b want 1/0", resp_data_ok, resp_err); else pass_cnt++;
    chk_cnt++; if (sram_wen !== 4'h0) $display("FAIL wr_wen_drop: got %b want 0000", sram_wen); else pass_cnt++;
    step();
  endtask

  task automatic test_misaligned();
    set_req(1'b1, 32'h8000_0001, 3'd1, 4'h0, 32'h0);
    step();
    // ERR cycle still accepts: size 3 follows immediately
    set_req(1'b1, 32'h8000_0000, 3'd3, 4'h0, 32'h0);
    sram_rdata = 32'hCAFE_F00D;
    chk_cnt++; if (resp_data_ok !== 1'b1 || resp_err !== 1'b1) $display("FAIL mis_half: got ok=%b err=%b want 1/1", resp_data_ok, resp_err); else pass_cnt++;
    chk_cnt++; if (resp_rdata !== 32'h0) $display("FAIL mis_rdata: got %h want 0", resp_rdata); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b0) $display("FAIL mis_half_en: got %b want 0", sram_en); else pass_cnt++;
    chk_cnt++; if (resp_addr_ok !== 1'b1) $display("FAIL mis_aok: got %b want 1", resp_addr_ok); else pass_cnt++;
    step();
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    chk_cnt++; if (resp_data_ok !== 1'b1 || resp_err !== 1'b1) $display("FAIL mis_size3: got ok=%b err=%b want 1/1", resp_data_ok, resp_err); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b0) $display("FAIL mis_size3_en: got %b want 0", sram_en); else pass_cnt++;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b0 || sram_en !== 1'b0) $display("FAIL mis_after: got ok=%b en=%b want 0/0", resp_data_ok, sram_en); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 32'h8000_0000, 3'd2, 4'h0, 32'h0);
    step();
    chk_cnt++; if (resp_addr_ok !== 1'b0 || sram_en !== 1'b1 || sram_addr !== 32'h0) $display("FAIL b2b_t1: got aok=%b en=%b addr=%h want 0/1/0", resp_addr_ok, sram_en, sram_addr); else pass_cnt++;
    req_addr   = 32'h8000_0004;
    sram_rdata = 32'h1111_1111;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b1 || resp_rdata !== 32'h1111_1111 || resp_addr_ok !== 1'b1) $display("FAIL b2b_t2: got dok=%b rdata=%h aok=%b want 1/11111111/1", resp_data_ok, resp_rdata, resp_addr_ok); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b0) $display("FAIL b2b_t2_en: got %b want 0", sram_en); else pass_cnt++;
    step();
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    chk_cnt++; if (resp_addr_ok !== 1'b0 || sram_en !== 1'b1 || sram_addr !== 32'h0000_0004) $display("FAIL b2b_t3: got aok=%b en=%b addr=%h want 0/1/4", resp_addr_ok, sram_en, sram_addr); else pass_cnt++;
    chk_cnt++; if (resp_data_ok !== 1'b0) $display("FAIL b2b_t3_dok: got %b want 0", resp_data_ok); else pass_cnt++;
    sram_rdata = 32'h2222_2222;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b1 || resp_rdata !== 32'h2222_2222) $display("FAIL b2b_t4: got dok=%b rdata=%h want 1/22222222", resp_data_ok, resp_rdata); else pass_cnt++;
    step();
    chk_cnt++; if (resp_data_ok !== 1'b0) $display("FAIL b2b_t5: got %b want 0", resp_data_ok); else pass_cnt++;
  endtask

  task automatic test_passthrough();
    set_req(1'b1, 32'h0040_0000, 3'd2, 4'h0, 32'h0);
    step();
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    chk_cnt++; if (sram_en !== 1'b1 || sram_addr !== 32'h0040_0000) $display("FAIL kuseg: got en=%b addr=%h want 1/00400000", sram_en, sram_addr); else pass_cnt++;
    step();
    set_req(1'b1, 32'hC000_0000, 3'd2, 4'h0, 32'h0);
    step();
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    chk_cnt++; if (sram_en !== 1'b1 || sram_addr !== 32'hC000_0000) $display("FAIL kseg2: got en=%b addr=%h want 1/c0000000", sram_en, sram_addr); else pass_cnt++;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int dok_seen;
    dok_seen = 0;
    set_req(1'b1, 32'h8000_0010, 3'd2, 4'hF, 32'hA5A5_A5A5);
    step();
    set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
    chk_cnt++; if (sram_en !== 1'b1 || sram_wen !== 4'hF) $display("FAIL mid_issue: got en=%b wen=%h want 1/f", sram_en, sram_wen); else pass_cnt++;
    #1 resetn = 1'b0;
    #1;
    chk_cnt++; if (sram_en !== 1'b0 || sram_wen !== 4'h0 || resp_addr_ok !== 1'b0) $display("FAIL mid_drop: got en=%b wen=%h aok=%b want 0/0/0", sram_en, sram_wen, resp_addr_ok); else pass_cnt++;
    step();
    resetn = 1'b1;
    step();
    chk_cnt++; if (resp_addr_ok !== 1'b1) $display("FAIL mid_rel_aok: got %b want 1", resp_addr_ok); else pass_cnt++;
    chk_cnt++; if (sram_en !== 1'b0 || sram_wen !== 4'h0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0) $display("FAIL mid_rel_sram: got en=%b wen=%h addr=%h wd=%h want 0", sram_en, sram_wen, sram_addr, sram_wdata); else pass_cnt++;
    chk_cnt++; if (resp_data_ok !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) $display("FAIL mid_rel_resp: got ok=%b err=%b rdata=%h want 0", resp_data_ok, resp_err, resp_rdata); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_data_ok === 1'b1) dok_seen++;
    end
    chk_cnt++; if (dok_seen != 0) $display("FAIL mid_no_dok: got %0d responses want 0", dok_seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_byte_write();
    test_misaligned();
    test_back_to_back();
    test_passthrough();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dbus_sram_ctrl.md
# dbus_sram_ctrl

Sequential bridge between the core's data-bus request/response port and a synchronous single-port data SRAM with one-cycle read latency. Each accepted request is latched into a one-entry buffer and its virtual address is translated: kseg0/kseg1 are folded to physical, all other segments pass through unchanged. It checks alignment, issues exactly one SRAM access per legal request and returns a data_ok response. It sits directly upstream of the top-level data_sram_* pins and replaces the combinational dbus-to-SRAM path.

## Interface
Parameters:
- none; widths fixed at 32-bit address/data, 4-bit byte strobe.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_addr  in  32  virtual byte address
- req_size  in  3  0=byte, 1=half, 2=word; 3..7 illegal
- req_strobe  in  4  byte write enables; 4'b0000 means read
- req_wdata  in  32  write data, lane-aligned by core
- resp_addr_ok  out  1  request accepted this cycle when req_valid also high
- resp_data_ok  out  1  response valid this cycle (one-cycle pulse per request)
- resp_rdata  out  32  read word (raw, unshifted); meaningful only with data_ok, no error, read
- resp_err  out  1  qualifies data_ok: misaligned/illegal-size request, no SRAM access made
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  physical address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

## Operation
- States: IDLE, ISSUE, WAIT, ERR.
- resp_addr_ok = 1 in IDLE, WAIT and ERR; 0 in ISSUE and while resetn low.
- Handshake: request accepted on edge where req_valid && resp_addr_ok; addr, size, strobe, wdata latched into buffer. Core may change inputs after acceptance.
- Legality: size 0 always legal; size 1 needs addr[0]==0; size 2 needs addr[1:0]==0; size ≥3 illegal.
- Accept legal -> ISSUE; accept illegal -> ERR; no accept from WAIT/ERR -> IDLE; IDLE with no accept stays IDLE.
- ISSUE: sram_en=1, sram_wen=latched strobe, sram_addr=translated latched addr, sram_wdata=latched wdata; -> WAIT unconditionally.
- WAIT: resp_data_ok=1, resp_err=0, resp_rdata=sram_rdata (for writes too, value don't-care).
- ERR: resp_data_ok=1, resp_err=1, resp_rdata=0; sram_en never asserted for the request.
- Translation on latched addr: addr[31:29] in {3'b100, 3'b101} -> {3'b000, addr[28:0]}; otherwise unchanged.
- Strobe passed verbatim; no cross-check against size (core's responsibility).
- Outside ISSUE: sram_en=0, sram_wen=0, sram_addr/sram_wdata hold buffer contents.

## Timing
- Reset (async assert, sync-release effect): state=IDLE, buffer=0, all outputs 0; resp_addr_ok rises first cycle after resetn high.
- Legal request accepted at edge T: sram_en high in cycle T+1, resp_data_ok in cycle T+2.
- Illegal request accepted at edge T: resp_data_ok+resp_err in cycle T+1.
- Back-to-back: new request accepted in the WAIT/ERR cycle; sustained throughput 1 legal request / 2 cycles, 1 illegal / 1 cycle.
- Simultaneous response and accept in WAIT: current response unaffected by the newly latched request.
- Reset mid-operation (ISSUE or WAIT): in-flight access dropped, no data_ok issued afterwards; sram_en/wen drop immediately with resetn.
- Exactly one data_ok per accepted request, in acceptance order.

## Test plan
- Read word at 0x8000_1000, SRAM returns 0xDEADBEEF -> sram_en=1, wen=0, sram_addr=0x0000_1000 in T+1; data_ok=1, rdata=0xDEADBEEF, err=0 in T+2.
- Byte write to 0xBFC0_0003, strobe 4'b1000, wdata 0x5A00_0000 -> T+1 sram_addr=0x1FC0_0003, wen=4'b1000, wdata=0x5A00_0000; data_ok at T+2.
- Half read at 0x8000_0001 -> T+1 data_ok=1, err=1, rdata=0; sram_en stays 0 throughout. Same for size=3 at 0x8000_0000.
- Back-to-back word reads at 0x8000_0000 and 0x8000_0004 held valid -> accepts at T and T+2, sram_en at T+1 and T+3, data_ok at T+2 and T+4, addr_ok low in T+1 and T+3.
- Kuseg read at 0x0040_0000 and kseg2 read at 0xC000_0000 -> sram_addr passes through unchanged.
- resetn pulled low during ISSUE -> sram_en drops at once, no data_ok follows; first cycle after release addr_ok=1, all other outputs 0.
